alu_mdu_ctrl: RTL
=================

Name: alu_mdu_ctrl

Overview:
Parametrised successor to the combinational ALU control decoder. Decodes ALUOp/funct3/funct7 into the ALU control code for single-cycle operations, as before. Adds an iterative RV32M multiply/divide unit (MDU) with a start/done handshake and a pipeline stall output. Sits between the main control unit, the datapath ALU and the register-file write-back mux.

Parameters:
XLEN, 32, operand/result width (power of two, >= 8)
CTRL_W, 4, ALU control code width

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
ALUOp  in  3  operation class from main control
funct3  in  3  instruction[14:12]
funct7b5  in  1  instruction[30] (SUB/SRA select)
funct7b0  in  1  instruction[25] (M-extension select)
start  in  1  instruction valid in EX this cycle
op_a  in  XLEN  rs1 value
op_b  in  XLEN  rs2 value
ALU_control  out  CTRL_W  ALU operation code (combinational)
mdu_sel  out  1  write-back takes mdu_result (combinational)
stall  out  1  freeze PC/IF/ID/EX
mdu_done  out  1  one-cycle pulse: mdu_result valid
mdu_result  out  XLEN  MDU result (registered)

Behaviour:
- Reset (async, RESET=1): state IDLE, mdu_done=0, mdu_result=0, internal counters/accumulators 0. stall=0 in the same cycle.
- ALU_control decode (pure combinational, independent of state):
  - ALUOp 000 (R): ADD 0000, SUB 0001 (funct7b5=1), SLL 0101, SLT 1001, SLTU 1000, XOR 0100, SRL 0110, SRA 0111 (funct7b5=1), OR 0011, AND 0010.
  - ALUOp 011 (I): same map. funct3=101 with funct7b5=1 gives SRAI (0111). ADDI ignores funct7b5.
  - ALUOp 010 (L/S): 0000. ALUOp 001 (B): 0001. ALUOp 100 (LUI/AUIPC): 0000. All other values: 0000.
  - When ALUOp=000 and funct7b0=1: ALU_control=0000 and mdu_sel=1. Otherwise mdu_sel=0.
- MDU op = funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, CALC, DONE.
  - IDLE:
    - start & mdu_sel: latch operands, op, and operand signs (sign-magnitude conversion for signed ops). Set cnt=XLEN-1 and go to CALC.
    - Special divide cases go directly to DONE with the result preloaded:
      - Divide by zero: DIV/DIVU result all ones; REM/REMU result op_a.
      - Signed overflow (op_a=2^(XLEN-1), op_b=-1): DIV result op_a; REM result 0.
  - CALC: one bit per cycle.
    - Multiply: shift-add, 2*XLEN-bit product.
    - Divide: restoring, XLEN-bit quotient and remainder.
    - cnt decrements each cycle. When cnt==0, apply sign correction and go to DONE.
  - DONE: mdu_done=1 for exactly one cycle, mdu_result updated in that same cycle, then return to IDLE.
    - Result selection: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
    - Quotient sign = sign_a^sign_b. Remainder sign = sign of dividend.
- Latency, start in cycle 0:
  - Normal operation: CALC occupies cycles 1..XLEN, DONE is cycle XLEN+1.
  - Special cases: DONE is cycle 1.
- stall = (state==IDLE & start & mdu_sel) | (state==CALC). stall is 0 in DONE, so the pipeline advances and writes back mdu_result.
- start while not IDLE is ignored; operands are held internally and are not re-sampled.
- mdu_result holds its value until the next DONE.
- Reset asserted mid-CALC aborts: IDLE, mdu_done=0, mdu_result=0, no spurious done after release.

Decomposition:
- Package alu_pkg holds:
  - alu_ctrl_t enum (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLTU, SLT codes)
  - ALUOp constants (ALUOP_R, ALUOP_B, ALUOP_LS, ALUOP_I, ALUOP_U)
  - mdu_op_t enum
  - mdu_state_t enum
- Sub-module mdu_iter (parametrised XLEN) holds the FSM, counter and shift-add/restoring-divide datapath.
- The top-level module alu_mdu_ctrl holds the combinational decode and instantiates mdu_iter.

Test Plan:
- Decode sweep: ALUOp=000, funct3=000/101, funct7b5=1, funct7b0=0 -> ALU_control 0001/0111, stall=0. ALUOp=011, funct3=101, funct7b5=0 -> 0110. ALUOp=100 -> 0000.
- MUL/MULHU: op_a=0xFFFF_FFFF, op_b=0x0000_0002, start 1 cycle.
  - funct3=000 -> mdu_done at cycle 33, mdu_result=0xFFFF_FFFE.
  - funct3=011 -> 0x0000_0001.
  - stall high cycles 0..32.
- Signed divide: DIV -7/2 -> 0xFFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF (-1). MULH -1*-1 -> 0x0000_0000.
- Special cases, each with done at cycle 1:
  - DIVU 5/0 -> 0xFFFF_FFFF.
  - REM 5/0 -> 0x0000_0005.
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000.
  - REM of the same operands -> 0.
- Reset mid-CALC: start DIVU 100/3, assert RESET at cycle 10 for 1 cycle -> mdu_result=0, no mdu_done within 40 cycles. A new DIVU 100/3 -> 33 at cycle 33.
- start re-asserted with new operands during CALC -> ignored; original result delivered at the original cycle.

Source files
------------

// File: rtl/alu_mdu_ctrl_pkg.sv
// alu_pkg: shared ALU control codes, ALUOp classes and MDU encodings.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SLT  = 4'b1001
  } alu_ctrl_t;
  localparam logic [2:0] ALUOP_R  = 3'b000;
  localparam logic [2:0] ALUOP_B  = 3'b001;
  localparam logic [2:0] ALUOP_LS = 3'b010;
  localparam logic [2:0] ALUOP_I  = 3'b011;
  localparam logic [2:0] ALUOP_U  = 3'b100;
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_t;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply (shift-add) / divide (restoring), one bit per cycle.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  mdu_op_t         op_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  mdu_state_t state;
  mdu_op_t op;
  logic [CW-1:0] cnt;
  logic sa, sb;
  logic [XLEN-1:0] m, hi, lo;
  logic sa_in, sb_in, div0, ovf, ge;
  logic [XLEN-1:0] mag_a, mag_b, special, diff, nhi, nlo, q, r, res;
  logic [XLEN:0] sum, t;
  logic [2*XLEN-1:0] prod, prod_n;
  always_comb begin
    sa_in = (op_in == MDU_MULH || op_in == MDU_MULHSU || op_in == MDU_DIV || op_in == MDU_REM) && a_in[XLEN-1];
    sb_in = (op_in == MDU_MULH || op_in == MDU_DIV || op_in == MDU_REM) && b_in[XLEN-1];
    mag_a = sa_in ? -a_in : a_in;
    mag_b = sb_in ? -b_in : b_in;
    div0 = op_in[2] && b_in == '0;
    ovf = (op_in == MDU_DIV || op_in == MDU_REM) && a_in == MIN && &b_in;
    special = div0 ? (op_in[1] ? a_in : '1) : (op_in[1] ? '0 : a_in);
    // Multiply keeps the multiplier in lo and shifts the product in from the top;
    // divide shifts the dividend out of lo into hi and the quotient bits into lo.
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    t = {hi, lo[XLEN-1]};
    ge = t >= {1'b0, m};
    diff = t[XLEN-1:0] - m;
    nhi = op[2] ? (ge ? diff : t[XLEN-1:0]) : sum[XLEN:1];
    nlo = op[2] ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
    prod = {nhi, nlo};
    prod_n = (sa ^ sb) ? -prod : prod;
    q = (sa ^ sb) ? -nlo : nlo;
    r = sa ? -nhi : nhi;
    res = op == MDU_MUL ? prod_n[XLEN-1:0] : !op[2] ? prod_n[2*XLEN-1:XLEN] : !op[1] ? q : r;
    stall = (state == IDLE && go) || state == CALC;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op <= MDU_MUL;
      cnt <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      m <= '0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          op <= op_in;
          sa <= sa_in;
          sb <= sb_in;
          m <= op_in[2] ? mag_b : mag_a;
          lo <= op_in[2] ? mag_a : mag_b;
          hi <= '0;
          cnt <= CW'(XLEN - 1);
          if (div0 || ovf) begin
            result <= special;
            done <= 1'b1;
            state <= DONE;
          end else state <= CALC;
        end
        CALC: begin
          hi <= nhi;
          lo <= nlo;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result <= res;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: ALU control decode plus iterative M-extension unit with stall handshake.
module alu_mdu_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CTRL_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [2:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  input  logic              start,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [CTRL_W-1:0] ALU_control,
  output logic              mdu_sel,
  output logic              stall,
  output logic              mdu_done,
  output logic [XLEN-1:0]   mdu_result
);
  alu_ctrl_t f3_ctrl, ctrl;
  always_comb begin
    case (funct3)
      3'b000:  f3_ctrl = (ALUOp == ALUOP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  f3_ctrl = ALU_SLL;
      3'b010:  f3_ctrl = ALU_SLT;
      3'b011:  f3_ctrl = ALU_SLTU;
      3'b100:  f3_ctrl = ALU_XOR;
      3'b101:  f3_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  f3_ctrl = ALU_OR;
      default: f3_ctrl = ALU_AND;
    endcase
    mdu_sel = ALUOp == ALUOP_R && funct7b0;
    ctrl = mdu_sel ? ALU_ADD
         : (ALUOp == ALUOP_R || ALUOp == ALUOP_I) ? f3_ctrl
         : ALUOp == ALUOP_B ? ALU_SUB : ALU_ADD;
    ALU_control = CTRL_W'(ctrl);
  end
  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk(CLK),
    .rst(RESET),
    .go(start && mdu_sel),
    .op_in(mdu_op_t'(funct3)),
    .a_in(op_a),
    .b_in(op_b),
    .stall(stall),
    .done(mdu_done),
    .result(mdu_result)
  );
endmodule
